ifm_read_scheduler: RTL and testbench
=====================================

IFM_READ_SCHEDULER -- requirements
Module: ifm_read_scheduler

Interface
REQ-001 SHALL have parameter SIZE, default 8, meaning the per-buffer read-enable width (one bit per row bank).
REQ-002 SHALL have parameter TILE_DEPTH, default 16, meaning the number of read beats per tile (range 2..256).
REQ-003 SHALL have parameter ADDR_W, default 40, meaning the read-address width.
REQ-004 SHALL use one clock and an asynchronous, active-high reset; the ports are listed in the order of REQ-005 to REQ-015.
REQ-005 clock  input  1  rising-edge clock.
REQ-006 rst  input  1  asynchronous active-high reset.
REQ-007 i2c_finish_0/1/2  input  1 each  single-cycle pulse: the ifmap buffer k fill is complete.
REQ-008 array_ready  input  1  the PE array can accept a new tile.
REQ-009 buf_empty_0/1/2  output  1 each  buffer k is free for img2col filling.
REQ-010 ifm_rd_en_0/1/2  output  SIZE each  read enable for buffer k; all ones while that buffer is being read, otherwise zero.
REQ-011 ifm_rd_addr  output  ADDR_W  read beat address, zero-extended from the beat counter.
REQ-012 rd_buf_sel  output  2  index of the buffer being read (0..2).
REQ-013 tile_start  output  1  one-cycle pulse on the first read beat.
REQ-014 tile_done  output  1  one-cycle pulse after the last beat.
REQ-015 sched_err  output  1  sticky protocol-error flag.

Function
REQ-016 SHALL track each buffer k in one of three states: EMPTY, FULL, READING; buf_empty_k SHALL be 1 only in EMPTY.
REQ-017 i2c_finish_k while buffer k is EMPTY SHALL move it to FULL and push k onto a 3-entry fill-order FIFO.
REQ-018 i2c_finish_k while buffer k is FULL or READING SHALL be ignored: no push, no state change, and sched_err set to 1.
REQ-019 Simultaneous finish pulses on two or three buffers SHALL push in ascending index order within the same cycle.
REQ-020 The FIFO SHALL never overflow, because its depth equals the buffer count; its pointers wrap modulo 3.
REQ-021 The read FSM SHALL have three states: IDLE, READ, DONE.
REQ-022 IDLE SHALL go to READ when the FIFO is non-empty and array_ready=1; the FSM pops the head, latches rd_buf_sel, and marks that buffer READING.
REQ-023 A push and a pop in the same cycle SHALL both take effect.
REQ-024 READ SHALL assert ifm_rd_en_<sel> every cycle with ifm_rd_addr = 0, 1, ..., TILE_DEPTH-1, i.e. TILE_DEPTH consecutive beats with no stalls.
REQ-025 tile_start SHALL be high only on the beat with ifm_rd_addr=0, one cycle after array_ready was sampled.
REQ-026 After the beat TILE_DEPTH-1, READ SHALL go to DONE.
REQ-027 DONE SHALL last one cycle: tile_done=1 and the buffer returns to EMPTY.
REQ-028 buf_empty_<sel> SHALL read 1 from the cycle after DONE, and the FSM returns to IDLE.
REQ-029 Back-to-back tiles SHALL therefore have one idle gap: DONE, then IDLE, then READ.
REQ-030 array_ready SHALL be sampled only in IDLE; deassertion during READ SHALL not stall or abort the tile.
REQ-031 In IDLE and DONE, ifm_rd_en_* and ifm_rd_addr SHALL be 0.

Reset
REQ-032 While rst=1: all buffers EMPTY, so buf_empty_0/1/2=1.
REQ-033 While rst=1: FIFO empty, FSM in IDLE, rd_buf_sel=0, ifm_rd_en_*=0, ifm_rd_addr=0, tile_start=0, tile_done=0, sched_err=0.
REQ-034 Reset asserted mid-tile SHALL abort immediately with no tile_done; after rst deasserts, the first cycle SHALL show only the reset values.

Structure
REQ-035 The read-FSM state encodings, the buffer-state encodings (EMPTY/FULL/READING) and NUM_BUF=3 SHALL live in a shared ifm_pkg package.
REQ-036 The fill-order FIFO SHALL be one sub-module, buf_id_fifo (3 entries, 2-bit data, dual push port, single pop), with the scheduler FSM and beat counter in the parent.

Verification
REQ-037 Fill buffer 1 then buffer 0 with array_ready=1 -> tiles read in order sel=1 then sel=0, each with 16 beats, addr 0..15, and one tile_start and one tile_done per tile.
REQ-038 Pulse i2c_finish_0 and i2c_finish_2 in the same cycle -> FIFO order 0 then 2; buf_empty_0 and buf_empty_2 fall together on the next cycle.
REQ-039 Pulse i2c_finish_1 twice with no read in between -> sched_err=1 and stays 1; only one tile is read from buffer 1.
REQ-040 Buffer 0 FULL, array_ready=0 for 20 cycles, then 1 -> no read during the wait; tile_start fires exactly one cycle after array_ready rises.
REQ-041 Assert rst at beat 7 of a tile -> all outputs take their reset values asynchronously and all buf_empty_* read 1; no tile_done is seen.
REQ-042 All three buffers FULL and array_ready held at 1 -> three tiles back-to-back, each separated by exactly one idle cycle; buf_empty_k rises the cycle after each tile_done.

Source files
------------

// File: rtl/ifm_pkg.sv
// Shared encodings for the ifmap read scheduler: buffer count, buffer states,
// read-FSM states and a modulo-3 pointer helper.
package ifm_pkg;

    localparam int NUM_BUF = 3;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_READ = 2'd1,
        ST_DONE = 2'd2
    } rd_st_t;

    typedef enum logic [1:0] {
        BUF_EMPTY   = 2'd0,
        BUF_FULL    = 2'd1,
        BUF_READING = 2'd2
    } buf_st_t;

    // a < 3 and b <= 3, so a single conditional subtract wraps the sum.
    function automatic logic [1:0] wrap3_add(input logic [1:0] a, input logic [1:0] b);
        logic [2:0] s;
        s = {1'b0, a} + {1'b0, b};
        if (s >= 3'd3) begin
            s = s - 3'd3;
        end
        return s[1:0];
    endfunction

endpackage

// File: rtl/buf_id_fifo.sv
// Fill-order FIFO of buffer ids: one push lane per buffer, written in ascending
// lane order within a cycle, single pop; depth equals the buffer count.
module buf_id_fifo
    import ifm_pkg::*;
(
    input  logic                   clock,
    input  logic                   rst,
    input  logic [NUM_BUF-1:0]     i_push,
    input  logic [2*NUM_BUF-1:0]   i_push_id,
    input  logic                   i_pop,
    output logic [1:0]             o_head,
    output logic                   o_empty
);

    logic [1:0] r_mem [NUM_BUF];
    logic [1:0] r_wr_ptr;
    logic [1:0] r_rd_ptr;
    logic [1:0] r_count;

    logic [1:0] w_off [NUM_BUF];
    logic [1:0] w_npush;
    logic       w_pop_ok;

    // Each active lane lands after the active lanes below it.
    always_comb begin
        w_npush = 2'd0;
        for (int k = 0; k < NUM_BUF; k++) begin
            w_off[k] = w_npush;
            w_npush  = w_npush + {1'b0, i_push[k]};
        end
    end

    assign w_pop_ok = i_pop && (r_count != 2'd0);

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= 2'd0;
            r_rd_ptr <= 2'd0;
            r_count  <= 2'd0;
            for (int k = 0; k < NUM_BUF; k++) begin
                r_mem[k] <= 2'd0;
            end
        end else begin
            for (int k = 0; k < NUM_BUF; k++) begin
                if (i_push[k]) begin
                    r_mem[wrap3_add(r_wr_ptr, w_off[k])] <= i_push_id[2*k +: 2];
                end
            end
            r_wr_ptr <= wrap3_add(r_wr_ptr, w_npush);
            if (w_pop_ok) begin
                r_rd_ptr <= wrap3_add(r_rd_ptr, 2'd1);
            end
            r_count <= r_count + w_npush - {1'b0, w_pop_ok};
        end
    end

    assign o_head  = r_mem[r_rd_ptr];
    assign o_empty = (r_count == 2'd0);

endmodule

// File: rtl/ifm_read_scheduler.sv
// Schedules tile reads from three img2col ifmap buffers in fill order and
// tracks each buffer's EMPTY/FULL/READING state.
module ifm_read_scheduler
    import ifm_pkg::*;
#(
    parameter int SIZE       = 8,
    parameter int TILE_DEPTH = 16,
    parameter int ADDR_W     = 40
) (
    input  logic              clock,
    input  logic              rst,
    input  logic              i2c_finish_0,
    input  logic              i2c_finish_1,
    input  logic              i2c_finish_2,
    input  logic              array_ready,
    output logic              buf_empty_0,
    output logic              buf_empty_1,
    output logic              buf_empty_2,
    output logic [SIZE-1:0]   ifm_rd_en_0,
    output logic [SIZE-1:0]   ifm_rd_en_1,
    output logic [SIZE-1:0]   ifm_rd_en_2,
    output logic [ADDR_W-1:0] ifm_rd_addr,
    output logic [1:0]        rd_buf_sel,
    output logic              tile_start,
    output logic              tile_done,
    output logic              sched_err
);

    localparam int            CW        = $clog2(TILE_DEPTH);
    localparam logic [CW-1:0] LAST_BEAT = CW'(TILE_DEPTH - 1);

    rd_st_t          r_state;
    buf_st_t         r_buf_st [NUM_BUF];
    logic [CW-1:0]   r_beat;
    logic [1:0]      r_sel;
    logic            r_rd_en;
    logic            r_tile_start;
    logic            r_tile_done;
    logic            r_err;

    logic [NUM_BUF-1:0]   w_fin;
    logic [NUM_BUF-1:0]   w_push;
    logic [2*NUM_BUF-1:0] w_push_id;
    logic                 w_bad_fin;
    logic                 w_pop;
    logic [1:0]           w_head;
    logic                 w_fifo_empty;

    assign w_fin     = {i2c_finish_2, i2c_finish_1, i2c_finish_0};
    assign w_push_id = {2'd2, 2'd1, 2'd0};

    always_comb begin
        for (int k = 0; k < NUM_BUF; k++) begin
            w_push[k] = w_fin[k] && (r_buf_st[k] == BUF_EMPTY);
        end
    end

    // A fill pulse on a buffer that is not EMPTY is a protocol error.
    assign w_bad_fin = |(w_fin & ~w_push);
    assign w_pop     = (r_state == ST_IDLE) && !w_fifo_empty && array_ready;

    buf_id_fifo u_fifo (
        .clock     (clock),
        .rst       (rst),
        .i_push    (w_push),
        .i_push_id (w_push_id),
        .i_pop     (w_pop),
        .o_head    (w_head),
        .o_empty   (w_fifo_empty)
    );

    always_ff @(posedge clock or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_beat       <= '0;
            r_sel        <= 2'd0;
            r_rd_en      <= 1'b0;
            r_tile_start <= 1'b0;
            r_tile_done  <= 1'b0;
            r_err        <= 1'b0;
            for (int k = 0; k < NUM_BUF; k++) begin
                r_buf_st[k] <= BUF_EMPTY;
            end
        end else begin
            r_tile_start <= 1'b0;
            r_tile_done  <= 1'b0;
            if (w_bad_fin) begin
                r_err <= 1'b1;
            end
            for (int k = 0; k < NUM_BUF; k++) begin
                if (w_push[k]) begin
                    r_buf_st[k] <= BUF_FULL;
                end
            end
            case (r_state)
                ST_IDLE: begin
                    if (w_pop) begin
                        r_state          <= ST_READ;
                        r_sel            <= w_head;
                        r_buf_st[w_head] <= BUF_READING;
                        r_rd_en          <= 1'b1;
                        r_tile_start     <= 1'b1;
                        r_beat           <= '0;
                    end
                end
                ST_READ: begin
                    if (r_beat == LAST_BEAT) begin
                        r_state     <= ST_DONE;
                        r_rd_en     <= 1'b0;
                        r_tile_done <= 1'b1;
                        r_beat      <= '0;
                    end else begin
                        r_beat <= r_beat + 1'b1;
                    end
                end
                ST_DONE: begin
                    r_buf_st[r_sel] <= BUF_EMPTY;
                    r_state         <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign buf_empty_0 = (r_buf_st[0] == BUF_EMPTY);
    assign buf_empty_1 = (r_buf_st[1] == BUF_EMPTY);
    assign buf_empty_2 = (r_buf_st[2] == BUF_EMPTY);

    assign ifm_rd_en_0 = (r_rd_en && (r_sel == 2'd0)) ? {SIZE{1'b1}} : '0;
    assign ifm_rd_en_1 = (r_rd_en && (r_sel == 2'd1)) ? {SIZE{1'b1}} : '0;
    assign ifm_rd_en_2 = (r_rd_en && (r_sel == 2'd2)) ? {SIZE{1'b1}} : '0;

    assign ifm_rd_addr = {{(ADDR_W - CW){1'b0}}, r_beat};
    assign rd_buf_sel  = r_sel;
    assign tile_start  = r_tile_start;
    assign tile_done   = r_tile_done;
    assign sched_err   = r_err;

endmodule

// File: tb/tb_ifm_read_scheduler.sv
// Directed bench for ifm_read_scheduler: fill-order reads, simultaneous fills,
// double-fill error, delayed array_ready, mid-tile reset, back-to-back tiles.
module tb_ifm_read_scheduler;

    localparam int SIZE = 8;
    localparam int TD   = 16;
    localparam int AW   = 40;

    logic            clock = 1'b0;
    logic            rst   = 1'b1;
    logic            fin0 = 1'b0, fin1 = 1'b0, fin2 = 1'b0;
    logic            array_ready = 1'b0;
    logic            be0, be1, be2;
    logic [SIZE-1:0] en0, en1, en2;
    logic [AW-1:0]   addr;
    logic [1:0]      sel;
    logic            tstart, tdone, err;

    int n_checks = 0;
    int n_fail   = 0;

    ifm_read_scheduler #(.SIZE(SIZE), .TILE_DEPTH(TD), .ADDR_W(AW)) dut (
        .clock        (clock),
        .rst          (rst),
        .i2c_finish_0 (fin0),
        .i2c_finish_1 (fin1),
        .i2c_finish_2 (fin2),
        .array_ready  (array_ready),
        .buf_empty_0  (be0),
        .buf_empty_1  (be1),
        .buf_empty_2  (be2),
        .ifm_rd_en_0  (en0),
        .ifm_rd_en_1  (en1),
        .ifm_rd_en_2  (en2),
        .ifm_rd_addr  (addr),
        .rd_buf_sel   (sel),
        .tile_start   (tstart),
        .tile_done    (tdone),
        .sched_err    (err)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    task automatic step();
        @(negedge clock);
    endtask

    function automatic logic bempty(input int k);
        return (k == 0) ? be0 : (k == 1) ? be1 : be2;
    endfunction

    // s < 0 means no buffer is being read.
    task automatic chk_beat(input string tag, input int s, input int a, input bit st, input bit dn);
        logic [63:0] ones;
        ones = {{(64-SIZE){1'b0}}, {SIZE{1'b1}}};
        chk({tag, " en0"}, 64'(en0), (s == 0) ? ones : 64'd0);
        chk({tag, " en1"}, 64'(en1), (s == 1) ? ones : 64'd0);
        chk({tag, " en2"}, 64'(en2), (s == 2) ? ones : 64'd0);
        chk({tag, " addr"}, 64'(addr), 64'(a));
        chk({tag, " start"}, 64'(tstart), 64'(st));
        chk({tag, " done"}, 64'(tdone), 64'(dn));
        if (s >= 0) chk({tag, " sel"}, 64'(sel), 64'(s));
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, " be0"}, 64'(be0), 64'd1);
        chk({tag, " be1"}, 64'(be1), 64'd1);
        chk({tag, " be2"}, 64'(be2), 64'd1);
        chk({tag, " sel"}, 64'(sel), 64'd0);
        chk({tag, " err"}, 64'(err), 64'd0);
        chk_beat(tag, -1, 0, 1'b0, 1'b0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        fin0 = 1'b0; fin1 = 1'b0; fin2 = 1'b0;
        array_ready = 1'b0;
        step();
        chk_reset("rst");
        rst = 1'b0;
    endtask

    // Entered on the beat-0 cycle; leaves on the cycle after the idle gap.
    task automatic read_tile(input int s);
        for (int b = 0; b < TD; b++) begin
            chk_beat($sformatf("tile%0d b%0d", s, b), s, b, b == 0, 1'b0);
            step();
        end
        chk_beat($sformatf("tile%0d done", s), -1, 0, 1'b0, 1'b1);
        chk($sformatf("tile%0d be@done", s), 64'(bempty(s)), 64'd0);
        step();
        chk_beat($sformatf("tile%0d gap", s), -1, 0, 1'b0, 1'b0);
        chk($sformatf("tile%0d be@gap", s), 64'(bempty(s)), 64'd1);
        step();
    endtask

    initial begin
        step();
        // Fill 1 then 0, array ready throughout
        do_reset();
        array_ready = 1'b1;
        fin1 = 1'b1;
        step();
        fin1 = 1'b0;
        chk("s1 be1 full", 64'(be1), 64'd0);
        chk("s1 no read yet", 64'(tstart), 64'd0);
        fin0 = 1'b1;
        step();
        fin0 = 1'b0;
        chk("s1 be0 full", 64'(be0), 64'd0);
        read_tile(1);
        read_tile(0);
        chk_beat("s1 idle", -1, 0, 1'b0, 1'b0);
        chk("s1 err", 64'(err), 64'd0);

        // Simultaneous fills of 0 and 2
        do_reset();
        fin0 = 1'b1; fin2 = 1'b1;
        step();
        fin0 = 1'b0; fin2 = 1'b0;
        chk("s2 be0", 64'(be0), 64'd0);
        chk("s2 be1", 64'(be1), 64'd1);
        chk("s2 be2", 64'(be2), 64'd0);
        array_ready = 1'b1;
        step();
        read_tile(0);
        read_tile(2);
        chk_beat("s2 idle", -1, 0, 1'b0, 1'b0);

        // Double fill of buffer 1
        do_reset();
        fin1 = 1'b1;
        step();
        fin1 = 1'b0;
        chk("s3 err after 1st", 64'(err), 64'd0);
        fin1 = 1'b1;
        step();
        fin1 = 1'b0;
        chk("s3 err after 2nd", 64'(err), 64'd1);
        array_ready = 1'b1;
        step();
        read_tile(1);
        for (int i = 0; i < 4; i++) begin
            chk_beat("s3 no 2nd tile", -1, 0, 1'b0, 1'b0);
            chk("s3 err sticky", 64'(err), 64'd1);
            step();
        end

        // Buffer 0 full, array not ready for 20 cycles
        do_reset();
        fin0 = 1'b1;
        step();
        fin0 = 1'b0;
        for (int i = 0; i < 20; i++) begin
            chk_beat("s4 wait", -1, 0, 1'b0, 1'b0);
            step();
        end
        array_ready = 1'b1;
        step();
        read_tile(0);

        // Reset at beat 7
        do_reset();
        array_ready = 1'b1;
        fin0 = 1'b1;
        step();
        fin0 = 1'b0;
        step();
        for (int i = 0; i < 7; i++) begin
            chk("s5 addr", 64'(addr), 64'(i));
            step();
        end
        chk("s5 addr", 64'(addr), 64'd7);
        #2 rst = 1'b1;
        #1 chk_reset("s5 async");
        step();
        rst = 1'b0;
        step();
        chk_reset("s5 post");
        for (int i = 0; i < 5; i++) begin
            chk("s5 no done", 64'(tdone), 64'd0);
            step();
        end

        // All three full, back-to-back tiles
        do_reset();
        fin0 = 1'b1; fin1 = 1'b1; fin2 = 1'b1;
        step();
        fin0 = 1'b0; fin1 = 1'b0; fin2 = 1'b0;
        chk("s6 be0", 64'(be0), 64'd0);
        chk("s6 be1", 64'(be1), 64'd0);
        chk("s6 be2", 64'(be2), 64'd0);
        array_ready = 1'b1;
        step();
        read_tile(0);
        read_tile(1);
        read_tile(2);
        chk_beat("s6 idle", -1, 0, 1'b0, 1'b0);
        chk("s6 err", 64'(err), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
